digit_ram_param: RTL
====================

DIGIT_RAM_PARAM -- requirements
Module: digit_ram_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, digit word width in bits (>=1).
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter RDW_MODE, default 0, same-address read-during-write result: 0 = old data, 1 = new data.
REQ-004 SHALL use one clock and a synchronous, active-high reset, named as below.
REQ-005 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-006 SHALL have port sync_clear  input  1  synchronous active-high reset.
REQ-007 SHALL have port clear_req  input  1  request for a full-memory zero sweep.
REQ-008 SHALL have port we  input  1  write enable.
REQ-009 SHALL have port write_addr  input  ADDR_WIDTH  write address.
REQ-010 SHALL have port data  input  DATA_WIDTH  write data.
REQ-011 SHALL have port re  input  1  read enable.
REQ-012 SHALL have port read_addr  input  ADDR_WIDTH  read address.
REQ-013 SHALL have port q  output  DATA_WIDTH  registered read data.
REQ-014 SHALL have port q_valid  output  1  q updated this cycle by an accepted read.
REQ-015 SHALL have port busy  output  1  clear sweep in progress.
REQ-016 SHALL have port clear_done  output  1  one-cycle pulse at sweep completion.

Function
REQ-017 SHALL implement a two-state FSM: IDLE, CLEAR; ADDR_WIDTH-bit sweep counter clr_addr.
REQ-018 IDLE: we=1 SHALL write data to mem[write_addr] at the clock edge.
REQ-019 IDLE with clear_req=1 SHALL go to CLEAR with clr_addr=0; a write in the same cycle SHALL be dropped (clear wins).
REQ-020 CLEAR: each cycle SHALL write 0 to mem[clr_addr] and increment clr_addr; we SHALL be ignored.
REQ-021 CLEAR with clr_addr = 2**ADDR_WIDTH-1 SHALL write its last zero and return to IDLE; clr_addr wraps to 0.
REQ-022 busy SHALL be 1 exactly while in CLEAR, i.e. exactly 2**ADDR_WIDTH consecutive cycles per sweep.
REQ-023 clear_done SHALL be 1 for exactly the first cycle after busy falls, otherwise 0.
REQ-024 clear_req while busy=1 SHALL be ignored (no restart, no extension).
REQ-025 Read: re=1 at edge N SHALL give q and q_valid=1 after edge N; latency 1 cycle.
REQ-026 re=0 SHALL hold q at its previous value and drive q_valid=0.
REQ-027 A read accepted while busy=1 SHALL return q=0 with q_valid=1, regardless of sweep progress.
REQ-028 IDLE, we=1, re=1, write_addr=read_addr: q SHALL be the prior word if RDW_MODE=0, the new data if RDW_MODE=1.
REQ-029 Reads and writes to different addresses in the same cycle SHALL both complete with no interaction.
REQ-030 Memory SHALL be a plain array; no per-cycle whole-array clear loops; zeroing happens only via the sweep.

Reset
REQ-031 sync_clear=1 at an edge SHALL set state=CLEAR, clr_addr=0, q=0, q_valid=0, clear_done=0, busy=1.
REQ-032 While sync_clear stays 1, clr_addr SHALL hold at 0, and we, re, clear_req SHALL be ignored.
REQ-033 After sync_clear falls, a full 2**ADDR_WIDTH-cycle sweep SHALL run; memory is all-zero when busy falls.
REQ-034 sync_clear asserted mid-sweep or mid-operation SHALL restart the sweep from address 0; in-flight reads produce no q_valid.
REQ-035 Memory contents SHALL be undefined only until the first post-reset sweep completes; reads during it return 0 (REQ-027).

Verification
REQ-036 Reset then release (defaults): busy=1 for 128 cycles, then clear_done=1 for one cycle; a read of addr 0x55 returns q=0.
REQ-037 IDLE: write 0xA to addr 3; next cycle re addr 3 -> one cycle later q=0xA, q_valid=1; re=0 next -> q stays 0xA, q_valid=0.
REQ-038 mem[5]=0x3; same cycle we=1 data=0xC, re=1, both addr 5 -> q=0x3 (RDW_MODE=0) or q=0xC (RDW_MODE=1); next read gives 0xC.
REQ-039 Fill addr 0..127 with addr[3:0]; pulse clear_req with we=1 addr 9 data 0xF -> busy 128 cycles, write dropped, every address reads 0 afterwards.
REQ-040 clear_req mid-sweep at cycle 60 -> busy still ends after 128 total cycles; sync_clear at cycle 60 -> busy extends to 128 cycles after release.
REQ-041 DATA_WIDTH=8, ADDR_WIDTH=4: write 0xFF to addr 15, read back 0xFF; clear sweep lasts 16 cycles.

Source files
------------

// File: rtl/digit_ram_param.sv
// digit_ram_param: parameterised digit RAM with a sweep-based zero clear and registered reads
module digit_ram_param #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  sync_clear,
  input  logic                  clear_req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  busy,
  output logic                  clear_done
);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d, wr_addr;
  logic [DATA_WIDTH-1:0] q_q, q_d, wr_data;
  logic [DATA_WIDTH-1:0] mem [0:2**ADDR_WIDTH-1];
  logic q_valid_q, q_valid_d, clear_done_q, clear_done_d, wr_en;
  assign busy       = state_q == CLEAR;
  assign q          = q_q;
  assign q_valid    = q_valid_q;
  assign clear_done = clear_done_q;
  // next state, sweep counter, write port selection and read result
  always_comb begin
    state_d      = sync_clear ? CLEAR : busy ? (clr_addr_q == LAST ? IDLE : CLEAR) : (clear_req ? CLEAR : IDLE);
    clr_addr_d   = (sync_clear || !busy) ? '0 : clr_addr_q + 1'b1;
    wr_en        = !sync_clear && (busy || (we && !clear_req));
    wr_addr      = busy ? clr_addr_q : write_addr;
    wr_data      = busy ? '0 : data;
    q_valid_d    = !sync_clear && re;
    q_d          = sync_clear ? '0 : !re ? q_q : busy ? '0 :
                   (RDW_MODE != 0 && wr_en && write_addr == read_addr) ? data : mem[read_addr];
    clear_done_d = !sync_clear && busy && clr_addr_q == LAST;
  end
  // control and read-data registers
  always_ff @(posedge clk) begin
    if (sync_clear) begin
      state_q      <= CLEAR;
      clr_addr_q   <= '0;
      q_q          <= '0;
      q_valid_q    <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      q_q          <= q_d;
      q_valid_q    <= q_valid_d;
      clear_done_q <= clear_done_d;
    end
  end
  // storage array, zeroed only by the sweep
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule
